// File: rtl/counter_pkg.sv
// Shared definitions for the 4-mode counter and its in-line checker.
package counter_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    MODE_UP3   = 2'b00,
    MODE_DOWN1 = 2'b01,
    MODE_UP1   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] STEP_UP3    = 4'd3;
  localparam logic [CNT_W-1:0] RCO_UP3_MIN = 4'd13;

endpackage

// File: rtl/counter_ref_model.sv
// Reference model of the 4-mode counter plus the check-enable flags that
// qualify the following cycle's compare.
module counter_ref_model
  import counter_pkg::*;
(
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [1:0]       MODO,
  input  logic [CNT_W-1:0] D,
  output logic [CNT_W-1:0] exp_q,
  output logic             exp_rco,
  output logic             exp_load,
  output logic             synced,
  output logic             chk_q,
  output logic             chk_rco,
  output logic             chk_load
);

  logic [CNT_W-1:0] exp_q_n;
  logic             exp_rco_n;
  logic             exp_load_n;
  logic             synced_n;
  logic             chk_rco_n;
  mode_e            mode;

  assign mode = mode_e'(MODO);

  always_comb begin
    exp_q_n    = exp_q;
    exp_rco_n  = exp_rco;
    exp_load_n = exp_load;
    synced_n   = synced;
    chk_rco_n  = 1'b1;
    if (!ENABLE) begin
      // Counter output is tri-stated: its value is lost until the next load.
      synced_n = 1'b0;
    end else if (mode == MODE_LOAD) begin
      exp_q_n    = D;
      exp_rco_n  = 1'b0;
      exp_load_n = 1'b1;
      synced_n   = 1'b1;
    end else begin
      exp_load_n = 1'b0;
      if (!synced) begin
        chk_rco_n = 1'b0;
      end else begin
        case (mode)
          MODE_UP3: begin
            exp_q_n   = exp_q + STEP_UP3;
            exp_rco_n = (exp_q >= RCO_UP3_MIN);
          end
          MODE_DOWN1: begin
            exp_q_n   = exp_q - 4'd1;
            exp_rco_n = (exp_q == '0);
          end
          default: begin
            exp_q_n   = exp_q + 4'd1;
            exp_rco_n = (exp_q == '1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      exp_q    <= '0;
      exp_rco  <= 1'b0;
      exp_load <= 1'b0;
      synced   <= 1'b1;
      chk_q    <= 1'b1;
      chk_rco  <= 1'b1;
      chk_load <= 1'b1;
    end else begin
      exp_q    <= exp_q_n;
      exp_rco  <= exp_rco_n;
      exp_load <= exp_load_n;
      synced   <= synced_n;
      chk_q    <= synced_n & ENABLE;
      chk_rco  <= chk_rco_n;
      chk_load <= 1'b1;
    end
  end

endmodule

// File: rtl/counter_checker.sv
// In-line monitor for the 4-mode counter: compares observed Q/RCO/LOAD with
// the reference model one cycle behind and reports pulses, sticky flag, count.
module counter_checker
  import counter_pkg::*;
#(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [1:0]       MODO,
  input  logic [CNT_W-1:0] D,
  input  logic [CNT_W-1:0] Q,
  input  logic             RCO,
  input  logic             LOAD,
  output logic             ERR_Q,
  output logic             ERR_RCO,
  output logic             ERR_LOAD,
  output logic             ERR_ANY,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic             SYNCED
);

  logic [CNT_W-1:0] exp_q;
  logic             exp_rco;
  logic             exp_load;
  logic             chk_q;
  logic             chk_rco;
  logic             chk_load;
  logic             mis_q;
  logic             mis_rco;
  logic             mis_load;
  logic             mis_any;

  counter_ref_model u_ref (
    .clk      (clk),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .MODO     (MODO),
    .D        (D),
    .exp_q    (exp_q),
    .exp_rco  (exp_rco),
    .exp_load (exp_load),
    .synced   (SYNCED),
    .chk_q    (chk_q),
    .chk_rco  (chk_rco),
    .chk_load (chk_load)
  );

  always_comb begin
    mis_q    = chk_q    & (Q    != exp_q);
    mis_rco  = chk_rco  & (RCO  != exp_rco);
    mis_load = chk_load & (LOAD != exp_load);
    mis_any  = mis_q | mis_rco | mis_load;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      ERR_Q     <= 1'b0;
      ERR_RCO   <= 1'b0;
      ERR_LOAD  <= 1'b0;
      ERR_ANY   <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      ERR_Q    <= mis_q;
      ERR_RCO  <= mis_rco;
      ERR_LOAD <= mis_load;
      ERR_ANY  <= ERR_ANY | mis_any;
      if (mis_any && (ERR_COUNT != '1))
        ERR_COUNT <= ERR_COUNT + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
